nes_dual_poll_scheduler: RTL



---
 rtl/nes_pkg.sv | 24 ++
 rtl/nes_dual_poll_scheduler_if.sv | 35 +++
 rtl/nes_pad_capture.sv | 56 +++++
 rtl/nes_dual_poll_scheduler.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared definitions for the dual NES pad poller.
// Holds the button bit map, the scheduler state encoding and the button word width.
package nes_pkg;

    localparam int unsigned NES_BTN_W = 8;
    localparam int unsigned NES_IDX_W = $clog2(NES_BTN_W);

    // Serial order out of the pad, which is also the bit position in the button word
    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        READ  = 2'd2
    } nes_state_e;

endpackage

// File: rtl/nes_dual_poll_scheduler_if.sv
// Bus between the dual NES pad poller and its surroundings.
//   frame_tick        poll request
//   data0 / data1     pad serial data, active-low
//   latch / nes_clk   shared pad latch and shift clock
//   buttons0/1        debounced-by-frame button words, 1 = pressed
//   pressed0/1        one-cycle press-edge pulses
//   valid             new button words this cycle
//   busy              a poll is in progress
// master: the scheduler side. slave: the game / pad side.
interface nes_dual_poll_scheduler_if;
    import nes_pkg::*;

    logic                 frame_tick;
    logic                 data0;
    logic                 data1;
    logic                 latch;
    logic                 nes_clk;
    logic [NES_BTN_W-1:0] buttons0;
    logic [NES_BTN_W-1:0] buttons1;
    logic [NES_BTN_W-1:0] pressed0;
    logic [NES_BTN_W-1:0] pressed1;
    logic                 valid;
    logic                 busy;

    modport master (
        input  frame_tick, data0, data1,
        output latch, nes_clk, buttons0, buttons1, pressed0, pressed1, valid, busy
    );

    modport slave (
        output frame_tick, data0, data1,
        input  latch, nes_clk, buttons0, buttons1, pressed0, pressed1, valid, busy
    );

endinterface

// File: rtl/nes_pad_capture.sv
// Per-pad capture and publish stage.
// Collects one inverted serial bit per sample strobe into a shadow register, and on
// commit publishes it as the button word together with its press-edge pulses.
//   clk, reset   system clock, synchronous active-high reset
//   sample_i     capture data_n_i into bit bit_idx_i
//   bit_idx_i    button index of the bit being shifted out
//   data_n_i     pad serial data, active-low
//   commit_i     publish the shadow word
//   buttons_o    published button word
//   pressed_o    one-cycle rising-edge pulses of buttons_o
module nes_pad_capture
    import nes_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_i,
    input  logic [NES_IDX_W-1:0] bit_idx_i,
    input  logic                 data_n_i,
    input  logic                 commit_i,
    output logic [NES_BTN_W-1:0] buttons_o,
    output logic [NES_BTN_W-1:0] pressed_o
);

    logic [NES_BTN_W-1:0] cap_q, cap_d;
    logic [NES_BTN_W-1:0] buttons_q, buttons_d;
    logic [NES_BTN_W-1:0] pressed_q, pressed_d;

    always_comb begin
        cap_d     = cap_q;
        buttons_d = buttons_q;
        pressed_d = '0;
        if (sample_i) begin
            cap_d[bit_idx_i] = ~data_n_i;
        end
        if (commit_i) begin
            buttons_d = cap_q;
            pressed_d = cap_q & ~buttons_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q     <= '0;
            buttons_q <= '0;
            pressed_q <= '0;
        end else begin
            cap_q     <= cap_d;
            buttons_q <= buttons_d;
            pressed_q <= pressed_d;
        end
    end

    assign buttons_o = buttons_q;
    assign pressed_o = pressed_q;

endmodule

// File: rtl/nes_dual_poll_scheduler.sv
// Polls two NES pads sharing latch and nes_clk, publishing both button words atomically
// with a valid strobe and press-edge pulses once per poll.
//   clk, reset   system clock, synchronous active-high reset
//   bus          nes_dual_poll_scheduler_if.master (see interface file for members)
// Optional build macro NES_AUTO_POLL_EN adds a free-running POLL_PERIOD request timer
// ORed with frame_tick.
module nes_dual_poll_scheduler
    import nes_pkg::*;
#(
    parameter int unsigned LATCH_CYC   = 1200,
    parameter int unsigned HALF_CYC    = 600,
    parameter int unsigned POLL_PERIOD = 1666667
) (
    input  logic                         clk,
    input  logic                         reset,
    nes_dual_poll_scheduler_if.master    bus
);

    if (LATCH_CYC < 1 || HALF_CYC < 1 || POLL_PERIOD < 1) begin : g_bad_param
        $error("LATCH_CYC, HALF_CYC and POLL_PERIOD must all be >= 1");
    end

    // One counter serves both the latch phase and the per-bit phase
    localparam int unsigned CntMax = (LATCH_CYC > 2 * HALF_CYC) ? LATCH_CYC - 1
                                                                 : 2 * HALF_CYC - 1;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax + 1) : 1;

    localparam logic [CntW-1:0] LatchLast = CntW'(LATCH_CYC - 1);
    localparam logic [CntW-1:0] HalfLast  = CntW'(HALF_CYC - 1);
    localparam logic [CntW-1:0] HalfCyc   = CntW'(HALF_CYC);
    localparam logic [CntW-1:0] BitLast   = CntW'(2 * HALF_CYC - 1);
    localparam logic [NES_IDX_W-1:0] IdxLast = NES_IDX_W'(NES_BTN_W - 1);

    nes_state_e           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [NES_IDX_W-1:0] bit_q, bit_d;
    logic                 pending_q, pending_d;
    logic                 latch_q, nes_clk_q, valid_q, busy_q;
    logic                 req;
    logic                 sample;
    logic                 commit;

`ifdef NES_AUTO_POLL_EN
    localparam int unsigned AutoW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [AutoW-1:0] AutoLast = AutoW'(POLL_PERIOD - 1);

    logic [AutoW-1:0] auto_cnt_q, auto_cnt_d;
    logic             auto_req;

    always_comb begin
        auto_req   = (auto_cnt_q == AutoLast);
        auto_cnt_d = auto_req ? '0 : auto_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end

    assign req = bus.frame_tick | auto_req;
`else
    assign req = bus.frame_tick;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        pending_d = pending_q;
        sample    = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req || pending_q) begin
                    state_d   = LATCH;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                end
            end
            LATCH: begin
                if (req) pending_d = 1'b1;
                if (cnt_q == LatchLast) begin
                    state_d = READ;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READ: begin
                if (req) pending_d = 1'b1;
                // Sample at the end of the low phase, before the rising nes_clk shifts the pad
                sample = (cnt_q == HalfLast);
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (bit_q == IdxLast) begin
                        // Publish edge; a request seen now (or earlier) chains the next poll
                        commit    = 1'b1;
                        pending_d = 1'b0;
                        state_d   = (req || pending_q) ? LATCH : IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            pending_q <= 1'b0;
            latch_q   <= 1'b0;
            nes_clk_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            pending_q <= pending_d;
            // Outputs decode the next state so they line up with the state register
            latch_q   <= (state_d == LATCH);
            nes_clk_q <= (state_d == READ) && (cnt_d >= HalfCyc);
            valid_q   <= commit;
            busy_q    <= (state_d != IDLE);
        end
    end

    logic [NES_BTN_W-1:0] buttons0, buttons1, pressed0, pressed1;

    nes_pad_capture u_pad0 (
        .clk       (clk),
        .reset     (reset),
        .sample_i  (sample),
        .bit_idx_i (bit_q),
        .data_n_i  (bus.data0),
        .commit_i  (commit),
        .buttons_o (buttons0),
        .pressed_o (pressed0)
    );

    nes_pad_capture u_pad1 (
        .clk       (clk),
        .reset     (reset),
        .sample_i  (sample),
        .bit_idx_i (bit_q),
        .data_n_i  (bus.data1),
        .commit_i  (commit),
        .buttons_o (buttons1),
        .pressed_o (pressed1)
    );

    assign bus.latch    = latch_q;
    assign bus.nes_clk  = nes_clk_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.buttons0 = buttons0;
    assign bus.buttons1 = buttons1;
    assign bus.pressed0 = pressed0;
    assign bus.pressed1 = pressed1;

endmodule
